tie_cfg_loader: RTL and testbench
=================================

# tie_cfg_loader

Programmable replacement for hard tie cells on the constant-control inputs of the gate-level datapath. It holds an active configuration word whose bits drive those inputs. It accepts a new word over a valid/ready handshake and forwards the word serially, LSB first, to a cascaded downstream loader. It then commits the word atomically, so the datapath never sees a partially updated configuration.

## Interface
- CFG_W, 8: configuration width in bits; legal range 1..32.
- CFG_RESET, 8'h01: value of cfg_q after reset. Matches the tie-high/tie-low defaults of the replaced cells.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a new configuration word is offered.
- in_ready  out  1  loader can accept a word; high only in IDLE.
- in_data  in  CFG_W  offered configuration word.
- so_valid  out  1  so_data carries a valid serial bit.
- so_ready  in  1  downstream accepts the current serial bit.
- so_data  out  1  serial bit, LSB of the word first.
- so_last  out  1  current serial bit is bit CFG_W-1.
- cfg_q  out  CFG_W  active configuration driving the datapath constant inputs.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse in the cycle cfg_q first shows the new word.

## Operation
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE
  - in_ready=1, so_valid=0, busy=0.
  - On in_valid && in_ready: staged <= in_data, bit counter <= 0, go to SHIFT.
- SHIFT
  - so_valid=1; so_data=staged[cnt]; so_last=(cnt==CFG_W-1).
  - On so_valid && so_ready: cnt increments.
  - If the accepted bit had so_last=1: cfg_q <= staged and go to DONE.
  - If so_ready=0: so_data, so_last and cnt hold unchanged. There is no timeout.
- DONE
  - done=1, busy=1, so_valid=0, in_ready=0.
  - Unconditional return to IDLE next edge.
- cfg_q changes only at the SHIFT->DONE edge and at reset. It never changes bit-by-bit during a shift.
- in_data is sampled only at acceptance. Later changes to in_data have no effect.
- in_valid while not in IDLE is ignored. There is no queueing; the producer holds in_valid until in_ready.
- Counter width is $clog2(CFG_W)+1. This covers CFG_W=1: a single SHIFT beat with so_last=1.
- Reset values (asynchronous, any state, including mid-shift):
  - state=IDLE, cfg_q=CFG_RESET, staged=0, cnt=0.
  - so_valid=0, so_data=0, so_last=0, done=0, busy=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
  - A shift interrupted by reset is lost. Downstream re-synchronises on its own reset.

## Timing
- Acceptance at edge E0. Bit k is presented in the cycle after E0+k, assuming so_ready held high.
- cfg_q is updated at edge E0+CFG_W; done is high in the following cycle.
- in_ready rises again at edge E0+CFG_W+1. Minimum word-to-word period is CFG_W+2 cycles.
- Each low cycle of so_ready during SHIFT adds exactly one cycle to all later events.
- All outputs are registered or decoded from state and registers only. There is no combinational path from any input to any output, except so_data/so_last from cnt and staged.

## Test plan
- Reset release: cfg_q=8'h01, in_ready=1, so_valid=0, done=0.
- Load 8'hA5 with so_ready=1:
  - so_data sequence is 1,0,1,0,0,1,0,1 on consecutive cycles.
  - so_last is high only on the 8th bit.
  - cfg_q=8'hA5 and done=1 exactly 9 cycles after acceptance.
  - in_ready=1 at cycle 10.
- Load 8'h3C with so_ready low on bits 2 and 5 for 3 cycles each:
  - Each held bit stays stable and no bit is duplicated or dropped.
  - done arrives 6 cycles later than the unstalled case.
- in_valid with 8'hFF asserted during SHIFT of 8'h0F: ignored; cfg_q becomes 8'h0F. The held 8'hFF is accepted the cycle in_ready returns.
- rst_n pulsed low after bit 3 of 8'hF0: cfg_q returns to 8'h01, so_valid drops immediately, no done pulse, next load works normally.
- CFG_W=1, CFG_RESET=0: load 1'b1 gives one so_valid beat with so_last=1, then cfg_q=1 with done two cycles after acceptance.

Source files
------------

// File: rtl/tie_cfg_if.sv
// tie_cfg_if: word-in and serial-out handshake bundle for tie_cfg_loader.
interface tie_cfg_if #(parameter int CFG_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic [CFG_W-1:0] in_data;
    logic             so_valid;
    logic             so_ready;
    logic             so_data;
    logic             so_last;
    modport master (output in_valid, in_data, so_ready, input in_ready, so_valid, so_data, so_last);
    modport slave  (input in_valid, in_data, so_ready, output in_ready, so_valid, so_data, so_last);
endinterface

// File: rtl/tie_cfg_loader.sv
// tie_cfg_loader: programmable tie-cell replacement; shifts a new word downstream LSB first,
// then commits it to cfg_q in a single edge so the datapath never sees a partial update.
module tie_cfg_loader #(
    parameter int               CFG_W     = 8,
    parameter logic [CFG_W-1:0] CFG_RESET = CFG_W'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    tie_cfg_if.slave         b,
    output logic [CFG_W-1:0] cfg_q,
    output logic             busy,
    output logic             done
);
    localparam int            CW   = $clog2(CFG_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(CFG_W - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_d;
    logic [CFG_W-1:0] staged;
    logic [CFG_W-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             accept, beat, last;
    always_comb begin
        accept  = state == IDLE && b.in_valid;
        beat    = state == SHIFT && b.so_ready;
        last    = cnt == LAST;
        sh      = staged >> cnt;
        state_d = accept ? SHIFT : (beat && last) ? DONE : state == DONE ? IDLE : state;
    end
    assign b.in_ready = state == IDLE;
    assign b.so_valid = state == SHIFT;
    assign b.so_data  = b.so_valid & sh[0];
    assign b.so_last  = b.so_valid & last;
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cfg_q  <= CFG_RESET;
            staged <= '0;
            cnt    <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                staged <= b.in_data;
                cnt    <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
            if (beat && last) cfg_q <= staged;
        end
    end
endmodule

// File: tb/tb_tie_cfg_loader.sv
// tb_tie_cfg_loader: randomized scoreboard bench for tie_cfg_loader (CFG_W=8 main, CFG_W=1 corner).
module tb_tie_cfg_loader;
    logic       clk = 0;
    logic       rst_n = 0;
    logic [7:0] cfg_q;
    logic       busy, done;
    logic [0:0] cfg1;
    logic       busy1, done1;
    int         checks = 0;
    int         errors = 0;
    logic       bits[$];
    logic [7:0] pend = 0;
    logic [7:0] exp_cfg = 8'h01;
    logic       exp_done = 0;
    logic       idle;
    logic [31:0] s;

    tie_cfg_if #(.CFG_W(8)) b ();
    tie_cfg_if #(.CFG_W(1)) b1 ();

    tie_cfg_loader #(.CFG_W(8), .CFG_RESET(8'h01)) dut (
        .clk(clk), .rst_n(rst_n), .b(b), .cfg_q(cfg_q), .busy(busy), .done(done));
    tie_cfg_loader #(.CFG_W(1), .CFG_RESET(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .b(b1), .cfg_q(cfg1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic stalled(input logic [31:0] m, input int c);
        return c < 32 && m[c[4:0]];
    endfunction

    // Cycles from acceptance to the done cycle: eight accepted beats, skipping stalled cycles.
    function automatic int lat(input logic [31:0] m);
        int c = 0;
        int k = 0;
        while (k < 8) begin
            if (!stalled(m, c)) k++;
            c++;
        end
        return c + 1;
    endfunction

    // Reference model: queue of bits still owed downstream, updated from the handshakes
    // that will fire at the coming rising edge (inputs are stable from posedge+1).
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            bits.delete();
            exp_cfg  = 8'h01;
            exp_done = 0;
        end else begin
            idle = bits.size() == 0 && !exp_done;
            chk("in_ready", b.in_ready, idle);
            chk("busy", busy, !idle);
            chk("so_valid", b.so_valid, bits.size() != 0);
            chk("done", done, exp_done);
            chk("cfg_q", cfg_q, exp_cfg);
            if (bits.size() != 0) begin
                chk("so_data", b.so_data, bits[0]);
                chk("so_last", b.so_last, bits.size() == 1);
            end
            exp_done = 0;
            if (bits.size() != 0 && b.so_ready) begin
                void'(bits.pop_front());
                if (bits.size() == 0) begin
                    exp_cfg  = pend;
                    exp_done = 1;
                end
            end else if (idle && b.in_valid) begin
                pend = b.in_data;
                for (int i = 0; i < 8; i++) bits.push_back(b.in_data[i]);
            end
        end
    end

    // Offer w, apply the so_ready stall mask per cycle after acceptance, and check done latency.
    task automatic load(input logic [7:0] w, input logic [31:0] stall, input int exp_n);
        int n;
        @(posedge clk);
        #1;
        b.so_ready = 1;
        b.in_valid = 1;
        b.in_data  = w;
        n = 0;
        @(negedge clk);
        while (!b.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 100, 1);
        @(posedge clk);
        #1;
        b.in_valid = 0;
        b.in_data  = 8'($urandom);
        if (exp_n < 0) return;
        for (n = 1; n <= 40; n++) begin
            b.so_ready = !stalled(stall, n - 1);
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            #1;
        end
        chk("done_latency", n, exp_n);
        @(posedge clk);
        #1;
        b.so_ready = 1;
        @(negedge clk);
        chk("in_ready_back", b.in_ready, 1);
    endtask

    initial begin
        b.in_valid  = 0;
        b.in_data   = 0;
        b.so_ready  = 1;
        b1.in_valid = 0;
        b1.in_data  = 0;
        b1.so_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("w1_reset_cfg", cfg1, 0);
        chk("w1_reset_ready", b1.in_ready, 1);
        @(posedge clk);
        #1;
        b1.in_valid = 1;
        b1.in_data  = 1'b1;
        @(posedge clk);
        #1;
        b1.in_valid = 0;
        b1.in_data  = 1'b0;
        @(negedge clk);
        chk("w1_so_valid", b1.so_valid, 1);
        chk("w1_so_last", b1.so_last, 1);
        chk("w1_so_data", b1.so_data, 1);
        chk("w1_cfg_hold", cfg1, 0);
        @(negedge clk);
        chk("w1_done", done1, 1);
        chk("w1_cfg", cfg1, 1);
        chk("w1_so_valid_off", b1.so_valid, 0);
        @(negedge clk);
        chk("w1_ready_back", b1.in_ready, 1);
        chk("w1_done_off", done1, 0);

        load(8'hA5, 32'h0, 9);
        load(8'h3C, 32'h0000_071C, 15);
        load(8'h0F, 32'h0, -1);
        b.in_valid = 1;
        b.in_data  = 8'hFF;
        load(8'hFF, 32'h0, 9);

        load(8'hF0, 32'h0, -1);
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("rst_so_valid", b.so_valid, 0);
        chk("rst_cfg_q", cfg_q, 8'h01);
        chk("rst_done", done, 0);
        chk("rst_in_ready", b.in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1;
        load(8'h96, 32'h0, 9);

        repeat (40) begin
            s = $urandom & $urandom;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            load(8'($urandom), s, lat(s));
        end
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
